frame_buffer_dbuf: RTL

//  Parametrised double-buffered frame store between the UART frame loader, default pattern generator and cube scan driver.

---
 rtl/lightcube_pkg.sv | 17 +
 rtl/fb_bank.sv | 40 ++++
 rtl/frame_buffer_dbuf.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lightcube_pkg.sv
// ============================================================================
// Module : lightcube_pkg
// Brief  : Shared cube frame geometry, row type and frame-buffer state encoding
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lightcube_pkg;
  localparam int CUBE_ROW_W = 8;
  localparam int CUBE_DEPTH = 64;

  typedef logic [CUBE_ROW_W-1:0] cube_row_t;

  typedef enum logic [1:0] {FB_FILL, FB_PENDING, FB_CLEAR} fb_state_t;
endpackage

`default_nettype wire

// File: rtl/fb_bank.sv
// ============================================================================
// Module : fb_bank
// Brief  : DEPTH x ROW_W register bank, sync write + clear port, parallel read
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_bank #(
  parameter int ROW_W = 8,
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [ROW_W-1:0] wdata,
  input  logic             clr,
  input  logic [IW-1:0]    caddr,
  output logic [ROW_W-1:0] rdata [DEPTH]
);

  logic [ROW_W-1:0] r_mem [DEPTH];

  // Clear and write never overlap (writes are blocked while clearing); clear wins anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clr) begin
      r_mem[caddr] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem;

endmodule

`default_nettype wire

// File: rtl/frame_buffer_dbuf.sv
// ============================================================================
// Module : frame_buffer_dbuf
// Brief  : Tear-free double-buffered cube frame store; FB_CLEAR_EN zeroes the
//          new back bank after every swap
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_buffer_dbuf
  import lightcube_pkg::*;
#(
  parameter int ROW_W = CUBE_ROW_W,
  parameter int DEPTH = CUBE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             display_mode,
  input  logic [ROW_W-1:0] frame_default [DEPTH],
  input  logic             frame_sync,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [ROW_W-1:0] wr_data,
  output logic             wr_ready,
  output logic             wr_err,
  input  logic             commit,
  output logic             swap_done,
  output logic             front_sel,
  output logic [ROW_W-1:0] frame_cube [DEPTH]
);

  localparam int        c_IW         = $clog2(DEPTH);
  localparam logic [1:0] c_ST_FILL    = FB_FILL;
  localparam logic [1:0] c_ST_PENDING = FB_PENDING;
  localparam logic [1:0] c_ST_CLEAR   = FB_CLEAR;

  logic [1:0]       r_state;
  logic             r_front_sel;
  logic             r_mode_q;
  logic             r_swap_done;
  logic             r_wr_err;
  logic [ROW_W-1:0] r_frame_cube [DEPTH];
  logic [ROW_W-1:0] w_bank_rd [2][DEPTH];
  logic             w_addr_ok;
  logic             w_wr_go;
  logic             w_swap;
  logic             w_clr;
  logic [c_IW-1:0]  w_clr_idx;

  assign wr_ready  = (r_state == c_ST_FILL);
  assign w_addr_ok = ({{(32-AW){1'b0}}, wr_addr} < 32'(DEPTH));
  assign w_wr_go   = wr_en & wr_ready & w_addr_ok;
  assign w_swap    = (r_state == c_ST_PENDING) & frame_sync;

`ifdef FB_CLEAR_EN
  logic [c_IW-1:0] r_clr_cnt;

  assign w_clr     = (r_state == c_ST_CLEAR);
  assign w_clr_idx = r_clr_cnt;
`else
  assign w_clr     = 1'b0;
  assign w_clr_idx = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_ST_FILL;
      r_front_sel <= 1'b0;
      r_swap_done <= 1'b0;
`ifdef FB_CLEAR_EN
      r_clr_cnt   <= '0;
`endif
    end else begin
      r_swap_done <= w_swap;
      case (r_state)
        c_ST_FILL: begin
          if (commit) r_state <= c_ST_PENDING;
        end
        c_ST_PENDING: begin
          if (frame_sync) begin
            r_front_sel <= ~r_front_sel;
`ifdef FB_CLEAR_EN
            r_state     <= c_ST_CLEAR;
            r_clr_cnt   <= '0;
`else
            r_state     <= c_ST_FILL;
`endif
          end
        end
`ifdef FB_CLEAR_EN
        c_ST_CLEAR: begin
          if (r_clr_cnt == c_IW'(DEPTH - 1)) begin
            r_state   <= c_ST_FILL;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
`endif
        default: r_state <= c_ST_FILL;
      endcase
    end
  end

  // Source select only moves on a frame boundary so a frame is never mixed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode_q <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en & ~(wr_ready & w_addr_ok);
      if (frame_sync) r_mode_q <= display_mode;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank #(
      .ROW_W (ROW_W),
      .DEPTH (DEPTH),
      .IW    (c_IW)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (w_wr_go & (1'(b) != r_front_sel)),
      .waddr (wr_addr[c_IW-1:0]),
      .wdata (wr_data),
      .clr   (w_clr & (1'(b) != r_front_sel)),
      .caddr (w_clr_idx),
      .rdata (w_bank_rd[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_frame_cube[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        r_frame_cube[i] <= r_mode_q ? w_bank_rd[r_front_sel][i] : frame_default[i];
    end
  end

  assign frame_cube = r_frame_cube;
  assign swap_done  = r_swap_done;
  assign front_sel  = r_front_sel;
  assign wr_err     = r_wr_err;

endmodule

`default_nettype wire
